// File: rtl/pipeline_sequencer_pkg.sv
// Shared types and constants for the pipeline run/step sequencer.
// The performance counters are built only when PIPE_SEQ_PERF_EN is defined.
package pipeline_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_STEP_WAIT = 3'd2,
    ST_STEP_EXEC = 3'd3,
    ST_DONE      = 3'd4
  } seq_state_t;

  // $zero never carries a real dependency, so it never causes a load-use stall.
  localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/pipeline_sequencer_load_use_detect.sv
// Combinational load-use hazard detector, shared with the forwarding unit.
module load_use_detect
  import pipeline_sequencer_pkg::*;
#(
  parameter int REG_SIZE = 5
) (
  input  logic                mem_read,
  input  logic [REG_SIZE-1:0] ex_rt,
  input  logic [REG_SIZE-1:0] rs,
  input  logic [REG_SIZE-1:0] rt,
  output logic                hazard
);

  assign hazard = mem_read
                & (ex_rt != REG_SIZE'(ZERO_REG))
                & ((ex_rt == rs) | (ex_rt == rt));

endmodule

// File: rtl/pipeline_sequencer.sv
// Run/step controller for the five-stage pipeline: enables, flushes, halt freeze.
// Optional cycle/stall counters are built when PIPE_SEQ_PERF_EN is defined.
module pipeline_sequencer
  import pipeline_sequencer_pkg::*;
#(
  parameter int CNT_WIDTH = 32,
  parameter int REG_SIZE  = 5
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic                 i_step_mode,
  input  logic                 i_step,
  input  logic                 i_halt_wb,
  input  logic                 i_id_ex_mem_read,
  input  logic [REG_SIZE-1:0]  i_id_ex_rt,
  input  logic [REG_SIZE-1:0]  i_if_id_rs,
  input  logic [REG_SIZE-1:0]  i_if_id_rt,
  input  logic                 i_branch_taken,
  output logic                 o_pipeline_enable,
  output logic                 o_pc_enable,
  output logic                 o_if_id_enable,
  output logic                 o_id_ex_flush,
  output logic                 o_if_id_flush,
  output logic                 o_running,
  output logic                 o_done,
  output logic [CNT_WIDTH-1:0] o_cycle_count,
  output logic [CNT_WIDTH-1:0] o_stall_count
);

  seq_state_t state, state_next;
  logic       en, en_next;
  logic       step_prev;
  logic       step_pulse;
  logic       hz;

  load_use_detect #(
    .REG_SIZE (REG_SIZE)
  ) u_load_use_detect (
    .mem_read (i_id_ex_mem_read),
    .ex_rt    (i_id_ex_rt),
    .rs       (i_if_id_rs),
    .rt       (i_if_id_rt),
    .hazard   (hz)
  );

  // Only the rising edge of i_step counts, so a wide pulse still gives one step.
  assign step_pulse = i_step & ~step_prev;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      en        <= 1'b0;
      step_prev <= 1'b0;
    end else begin
      state     <= state_next;
      en        <= en_next;
      step_prev <= i_step;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:      if (i_start) state_next = i_step_mode ? ST_STEP_WAIT : ST_RUN;
      ST_RUN:       if (i_halt_wb) state_next = ST_DONE;
      ST_STEP_WAIT: begin
        if (i_halt_wb)       state_next = ST_DONE;
        else if (step_pulse) state_next = ST_STEP_EXEC;
      end
      ST_STEP_EXEC: state_next = i_halt_wb ? ST_DONE : ST_STEP_WAIT;
      ST_DONE:      state_next = ST_DONE;
      default:      state_next = ST_IDLE;
    endcase
    en_next = (state_next == ST_RUN) || (state_next == ST_STEP_EXEC);
  end

  // A taken branch overrides the stall: the stalled instruction is on the wrong path.
  assign o_pipeline_enable = en;
  assign o_if_id_flush     = en & i_branch_taken;
  assign o_id_ex_flush     = en & (i_branch_taken | hz);
  assign o_pc_enable       = en & (i_branch_taken | ~hz);
  assign o_if_id_enable    = en & (i_branch_taken | ~hz);
  assign o_running         = (state != ST_IDLE) && (state != ST_DONE);
  assign o_done            = (state == ST_DONE);

`ifdef PIPE_SEQ_PERF_EN
  logic [CNT_WIDTH-1:0] cycle_count;
  logic [CNT_WIDTH-1:0] stall_count;

  // Saturating counters; they hold at all-ones rather than wrap.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cycle_count <= '0;
      stall_count <= '0;
    end else begin
      if (en && (cycle_count != '1))
        cycle_count <= cycle_count + CNT_WIDTH'(1);
      if (en && hz && !i_branch_taken && (stall_count != '1))
        stall_count <= stall_count + CNT_WIDTH'(1);
    end
  end

  assign o_cycle_count = cycle_count;
  assign o_stall_count = stall_count;
`else
  assign o_cycle_count = '0;
  assign o_stall_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed self-checking bench for pipeline_sequencer (works with or without PIPE_SEQ_PERF_EN).
module tb_pipeline_sequencer;

  localparam int CNT_WIDTH = 32;
  localparam int REG_SIZE  = 5;
`ifdef PIPE_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic                 i_clock = 1'b0;
  logic                 i_reset;
  logic                 i_start;
  logic                 i_step_mode;
  logic                 i_step;
  logic                 i_halt_wb;
  logic                 i_id_ex_mem_read;
  logic [REG_SIZE-1:0]  i_id_ex_rt;
  logic [REG_SIZE-1:0]  i_if_id_rs;
  logic [REG_SIZE-1:0]  i_if_id_rt;
  logic                 i_branch_taken;
  logic                 o_pipeline_enable;
  logic                 o_pc_enable;
  logic                 o_if_id_enable;
  logic                 o_id_ex_flush;
  logic                 o_if_id_flush;
  logic                 o_running;
  logic                 o_done;
  logic [CNT_WIDTH-1:0] o_cycle_count;
  logic [CNT_WIDTH-1:0] o_stall_count;

  int total = 0;
  int bad   = 0;
  int en_seen;

  pipeline_sequencer #(
    .CNT_WIDTH (CNT_WIDTH),
    .REG_SIZE  (REG_SIZE)
  ) dut (
    .i_clock           (i_clock),
    .i_reset           (i_reset),
    .i_start           (i_start),
    .i_step_mode       (i_step_mode),
    .i_step            (i_step),
    .i_halt_wb         (i_halt_wb),
    .i_id_ex_mem_read  (i_id_ex_mem_read),
    .i_id_ex_rt        (i_id_ex_rt),
    .i_if_id_rs        (i_if_id_rs),
    .i_if_id_rt        (i_if_id_rt),
    .i_branch_taken    (i_branch_taken),
    .o_pipeline_enable (o_pipeline_enable),
    .o_pc_enable       (o_pc_enable),
    .o_if_id_enable    (o_if_id_enable),
    .o_id_ex_flush     (o_id_ex_flush),
    .o_if_id_flush     (o_if_id_flush),
    .o_running         (o_running),
    .o_done            (o_done),
    .o_cycle_count     (o_cycle_count),
    .o_stall_count     (o_stall_count)
  );

  always #5 i_clock = ~i_clock;

  function automatic logic [63:0] exp_cnt(input int n);
    return PERF ? 64'(n) : 64'd0;
  endfunction

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic apply_stimulus(input logic mem_read, input logic [REG_SIZE-1:0] ex_rt,
                                input logic [REG_SIZE-1:0] rs, input logic [REG_SIZE-1:0] rt,
                                input logic branch);
    i_id_ex_mem_read = mem_read;
    i_id_ex_rt       = ex_rt;
    i_if_id_rs       = rs;
    i_if_id_rt       = rt;
    i_branch_taken   = branch;
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    i_reset = 1'b1; i_start = 1'b0; i_step_mode = 1'b0; i_step = 1'b0; i_halt_wb = 1'b0;
    apply_stimulus(1'b1, 5'd5, 5'd5, 5'd0, 1'b1);
    tick(); tick();

    // Reset state: enable gating keeps strobes low even with hazard/branch inputs active
    check_output("rst_en",       o_pipeline_enable, 0);
    check_output("rst_pc_en",    o_pc_enable, 0);
    check_output("rst_ifid_en",  o_if_id_enable, 0);
    check_output("rst_idex_fl",  o_id_ex_flush, 0);
    check_output("rst_ifid_fl",  o_if_id_flush, 0);
    check_output("rst_running",  o_running, 0);
    check_output("rst_done",     o_done, 0);
    check_output("rst_cycles",   o_cycle_count, 0);
    check_output("rst_stalls",   o_stall_count, 0);
    apply_stimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

    // Continuous run, halt reaches WB on the 10th enabled cycle
    i_reset = 1'b0; i_start = 1'b1; i_step_mode = 1'b0;
    tick();
    i_start = 1'b0;
    check_output("run_running", o_running, 1);
    en_seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (o_pipeline_enable) en_seen++;
      if (i == 9) i_halt_wb = 1'b1;
      tick();
    end
    i_halt_wb = 1'b0;
    check_output("run_en_cycles", 64'(en_seen), 10);
    check_output("run_halt_en",   o_pipeline_enable, 0);
    check_output("run_done",      o_done, 1);
    check_output("run_not_run",   o_running, 0);
    check_output("run_cycles",    o_cycle_count, exp_cnt(10));

    // DONE is sticky against start and step
    i_start = 1'b1; i_step = 1'b1; i_step_mode = 1'b1;
    tick(); tick();
    i_start = 1'b0; i_step = 1'b0;
    tick();
    check_output("done_en",     o_pipeline_enable, 0);
    check_output("done_done",   o_done, 1);
    check_output("done_cycles", o_cycle_count, exp_cnt(10));

    i_reset = 1'b1; tick(); i_reset = 1'b0;
    check_output("rst2_done",   o_done, 0);
    check_output("rst2_cycles", o_cycle_count, 0);

    // Single-step mode: three pulses spaced four cycles apart
    i_start = 1'b1; i_step_mode = 1'b1;
    tick();
    i_start = 1'b0;
    check_output("step_wait_en",  o_pipeline_enable, 0);
    check_output("step_running",  o_running, 1);
    en_seen = 0;
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 4; c++) begin
        i_step = (c == 0);
        tick();
        if (o_pipeline_enable) en_seen++;
      end
    end
    check_output("step_pulses", 64'(en_seen), 3);
    check_output("step_cycles", o_cycle_count, exp_cnt(3));

    // A three-cycle-wide step still advances once
    en_seen = 0;
    i_step = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c == 3) i_step = 1'b0;
      tick();
      if (o_pipeline_enable) en_seen++;
    end
    check_output("wide_step_pulses", 64'(en_seen), 1);
    check_output("wide_step_cycles", o_cycle_count, exp_cnt(4));

    // Halt wins over a simultaneous step in STEP_WAIT
    i_halt_wb = 1'b1; i_step = 1'b1;
    tick();
    i_halt_wb = 1'b0; i_step = 1'b0;
    check_output("step_halt_en",     o_pipeline_enable, 0);
    check_output("step_halt_done",   o_done, 1);
    check_output("step_halt_cycles", o_cycle_count, exp_cnt(4));

    i_reset = 1'b1; tick(); i_reset = 1'b0;

    // Load-use hazards and branches while running
    i_start = 1'b1; i_step_mode = 1'b0;
    tick();
    i_start = 1'b0;
    apply_stimulus(1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
    check_output("hz_pc_en",    o_pc_enable, 0);
    check_output("hz_ifid_en",  o_if_id_enable, 0);
    check_output("hz_idex_fl",  o_id_ex_flush, 1);
    check_output("hz_ifid_fl",  o_if_id_flush, 0);
    tick();
    check_output("hz_stalls",   o_stall_count, exp_cnt(1));
    check_output("hz_cycles",   o_cycle_count, exp_cnt(1));

    apply_stimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
    check_output("zero_pc_en",   o_pc_enable, 1);
    check_output("zero_idex_fl", o_id_ex_flush, 0);
    tick();
    check_output("zero_stalls",  o_stall_count, exp_cnt(1));

    apply_stimulus(1'b1, 5'd7, 5'd3, 5'd7, 1'b0);
    check_output("hz_rt_pc_en",  o_pc_enable, 0);
    apply_stimulus(1'b0, 5'd7, 5'd3, 5'd7, 1'b0);
    check_output("noload_pc_en", o_pc_enable, 1);
    check_output("noload_fl",    o_id_ex_flush, 0);

    apply_stimulus(1'b1, 5'd7, 5'd3, 5'd7, 1'b1);
    check_output("br_hz_ifid_fl", o_if_id_flush, 1);
    check_output("br_hz_idex_fl", o_id_ex_flush, 1);
    check_output("br_hz_pc_en",   o_pc_enable, 1);
    check_output("br_hz_ifid_en", o_if_id_enable, 1);
    tick();
    check_output("br_hz_stalls",  o_stall_count, exp_cnt(1));
    check_output("br_hz_cycles",  o_cycle_count, exp_cnt(3));

    apply_stimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    check_output("br_ifid_fl", o_if_id_flush, 1);
    check_output("br_idex_fl", o_id_ex_flush, 1);
    apply_stimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);

    // Reset in the middle of RUN at cycle 7, then restart
    tick(); tick(); tick(); tick();
    check_output("mid_cycles", o_cycle_count, exp_cnt(7));
    i_reset = 1'b1; tick(); i_reset = 1'b0;
    check_output("midrst_en",      o_pipeline_enable, 0);
    check_output("midrst_running", o_running, 0);
    check_output("midrst_done",    o_done, 0);
    check_output("midrst_cycles",  o_cycle_count, 0);
    check_output("midrst_stalls",  o_stall_count, 0);

    i_start = 1'b1; tick(); i_start = 1'b0;
    check_output("restart_en", o_pipeline_enable, 1);
    i_halt_wb = 1'b1; tick(); i_halt_wb = 1'b0;
    check_output("restart_done",   o_done, 1);
    check_output("restart_cycles", o_cycle_count, exp_cnt(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
